memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, CPU and memory data width.
- MEMORY_DEPTH, 1024, data memory depth in words.
- BASE_ADDRESS, 32'h1001_0000, byte address of data word 0.
REQ-002 Clock is clk and reset is reset; one clock, reset synchronous and active-low (name, direction, width, meaning), one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset.
- req  in  1  CPU request strobe.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  sign-extend sub-word loads.
- addr  in  32  CPU byte address.
- wdata  in  DATA_WIDTH  store data, right-aligned.
- rdata  out  DATA_WIDTH  load result, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  request in flight.
- err  out  1  error flag, valid while ready=1.
- mem_addr  out  $clog2(MEMORY_DEPTH)  word index to memory.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_write  out  1  memory write enable, committed at the next clk edge.
- mem_read  out  1  memory read enable.
- mem_rdata  in  DATA_WIDTH  combinational read data from memory.

Function
REQ-003 FSM states IDLE, READ, WRITE, DONE; a request is accepted only when req=1 in IDLE; req in any other state is ignored.
REQ-004 On acceptance, latch we, size, sign_ext, addr and wdata; later input changes have no effect on the request.
REQ-005 Word index = (addr - BASE_ADDRESS) >> 2, truncated to the mem_addr width.
REQ-006 err condition: size=11; or halfword with addr[0]=1; or word with addr[1:0]!=0; or addr < BASE_ADDRESS; or word index >= MEMORY_DEPTH.
REQ-007 An err request goes IDLE->DONE directly, with no mem_read or mem_write asserted.
REQ-008 Transitions:
- Load: IDLE->READ->DONE.
- Word store: IDLE->WRITE->DONE.
- Sub-word store: IDLE->READ->WRITE->DONE.
- DONE->IDLE always.
REQ-009 Latency from accepting edge to ready=1: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-010 mem_read=1 only in READ; at the end of READ the unit captures mem_rdata into an internal word register.
REQ-011 mem_write = (state==WRITE) & reset; no memory write commits on any edge where reset=0.
REQ-012 Lane order is little-endian:
- Byte lane k = bits [8k+7:8k], k = addr[1:0].
- Halfword lane h = bits [16h+15:16h], h = addr[1].
REQ-013 Load result: the selected lane, zero-extended, or sign-extended when sign_ext=1; a word load returns the full word.
REQ-014 Sub-word store: mem_wdata is the captured word with only the selected lane replaced by wdata[7:0] or wdata[15:0]; other lanes are unchanged.
REQ-015 Word store: mem_wdata = wdata.
REQ-016 rdata and err are registered, held until the next acceptance, and rdata = 0 after any store or error.
REQ-017 ready=1 only in DONE; busy=1 in READ, WRITE and DONE.
REQ-018 Back-to-back: req=1 in the cycle after DONE (IDLE) is accepted; minimum request spacing is therefore latency + 1 cycles.

Reset
REQ-019 While reset=0 at a clk edge: state=IDLE and rdata=0, err=0; ready, busy, mem_read and mem_write are all 0 in the following cycle.
REQ-020 Reset in any state aborts the request without a ready pulse; an interrupted read-modify-write leaves memory unmodified.

Structure
REQ-021 Package mau_pkg holds:
- State enum (IDLE, READ, WRITE, DONE).
- Size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- Default BASE_ADDRESS.
REQ-022 One combinational sub-module, lane_merge, performs lane extract with sign/zero extension and lane insert for stores; the FSM and registers stay in memory_access_unit.

Verification
REQ-023 The bench pairs the unit with a word-addressed RAM model: combinational read, write on clk edge.
REQ-024 Word store, then load:
- Stimulus: addr=32'h1001_0008, wdata=32'hDEAD_BEEF.
- Response: mem_addr=2; ready 2 cycles after each acceptance; load rdata=32'hDEAD_BEEF.
REQ-025 Byte store read-modify-write:
- Stimulus: word 0 = 32'h1122_3344; sb addr=32'h1001_0001, wdata=8'hAA.
- Response: word 0 = 32'h1122_AA44; ready 3 cycles after acceptance.
REQ-026 Byte loads:
- Stimulus: word 0 = 32'h0000_80FF; lb addr=32'h1001_0001 with sign_ext=1, then with sign_ext=0.
- Response: rdata=32'hFFFF_FF80, then 32'h0000_0080.
REQ-027 Errors:
- Stimulus: lw addr=32'h1001_0002; lw addr=32'h0FFF_FFFC; size=11.
- Response: err=1, rdata=0, ready 1 cycle after acceptance; mem_read and mem_write never asserted.
REQ-028 Reset during WRITE of an sh:
- Stimulus: assert reset=0 while in WRITE.
- Response: target word unchanged, no ready pulse, IDLE afterwards; a new request is accepted normally.
REQ-029 Ignored requests:
- Stimulus: hold req=1 throughout a store.
- Response: exactly one memory write; a second request is accepted in the IDLE cycle after DONE.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

endpackage

// File: rtl/memory_access_unit_lane_merge.sv
// Little-endian lane extract (with sign/zero extension) and lane insert.
module lane_merge
  import mau_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [1:0]            lane_off,
  input  logic [DATA_WIDTH-1:0] ext_word,
  input  logic [DATA_WIDTH-1:0] ins_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data_c,
  output logic [DATA_WIDTH-1:0] store_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed lane and extend it to the full width.
  always_comb begin
    byte_sel    = ext_word[{lane_off, 3'b000} +: 8];
    half_sel    = ext_word[{lane_off[1], 4'b0000} +: 16];
    load_data_c = ext_word;
    case (size)
      SIZE_BYTE: load_data_c = {{(DATA_WIDTH-8){sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data_c = {{(DATA_WIDTH-16){sign_ext & half_sel[15]}}, half_sel};
      default:   load_data_c = ext_word;
    endcase
  end

  // Store path: replace only the addressed lane of the captured word.
  always_comb begin
    store_data_c = ins_word;
    case (size)
      SIZE_BYTE: store_data_c[{lane_off, 3'b000} +: 8]     = wdata[7:0];
      SIZE_HALF: store_data_c[{lane_off[1], 4'b0000} +: 16] = wdata[15:0];
      default:   store_data_c = wdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// CPU load/store front end to a word-addressed data memory, with
// read-modify-write for sub-word stores and alignment/range checking.
module memory_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req,
  input  logic                            we,
  input  logic [1:0]                      size,
  input  logic                            sign_ext,
  input  logic [31:0]                     addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ready,
  output logic                            busy,
  output logic                            err,
  output logic [$clog2(MEMORY_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_write,
  output logic                            mem_read,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [1:0]            off_q, off_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           offset_c;
  logic                  req_err_c;
  logic [DATA_WIDTH-1:0] load_data_c;
  logic [DATA_WIDTH-1:0] store_data_c;

  // Classify the incoming request: misaligned, illegal size or out of range.
  always_comb begin
    offset_c  = addr - BASE_ADDRESS;
    req_err_c = (size == SIZE_ILLEGAL)
              | ((size == SIZE_HALF) & addr[0])
              | ((size == SIZE_WORD) & (addr[1:0] != 2'b00))
              | (addr < BASE_ADDRESS)
              | ((offset_c >> 2) >= 32'(MEMORY_DEPTH));
  end

  lane_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_merge (
    .size         (size_q),
    .sign_ext     (sext_q),
    .lane_off     (off_q),
    .ext_word     (mem_rdata),
    .ins_word     (word_q),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .store_data_c (store_data_c)
  );

  // State and request registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = addr[1:0];
          idx_d   = IDX_W'(offset_c >> 2);
          wdata_d = wdata;
          rdata_d = '0;
          err_d   = req_err_c;
          if (req_err_c)              state_d = DONE;
          else if (!we)               state_d = READ;
          else if (size == SIZE_WORD) state_d = WRITE;
          else                        state_d = READ;
        end
      end
      READ: begin
        word_d = mem_rdata;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_data_c;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Status and memory strobes decoded from the state register.
  always_comb begin
    rdata     = rdata_q;
    err       = err_q;
    ready     = (state_q == DONE);
    busy      = (state_q != IDLE);
    mem_read  = (state_q == READ);
    mem_write = (state_q == WRITE) & reset;
    mem_addr  = idx_q;
    mem_wdata = store_data_c;
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench: memory_access_unit paired with a word-addressed RAM model.
module tb_memory_access_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  int          wr_cnt;
  int          rd_cnt;
  int          rdy_cnt;
  logic [9:0]  last_waddr;

  int checks;
  int errors;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nw;
    int          nr;
    logic        chk;
    int          idx;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[$];

  memory_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the clock edge; strobe counters.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= mem_addr;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (ready)    rdy_cnt <= rdy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d, input logic h,
                              input int lat, input logic [31:0] rd, input logic er,
                              input int nw, input int nr, input logic c,
                              input int idx, input logic [31:0] word);
    vec_t v;
    v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = d; v.hold = h;
    v.lat = lat; v.rd = rd; v.er = er; v.nw = nw; v.nr = nr;
    v.chk = c; v.idx = idx; v.word = word;
    return v;
  endfunction

  // Issue one request from an IDLE cycle and return once back in IDLE.
  task automatic run(input vec_t v, output int lat, output logic [31:0] rd,
                     output logic er, output int nw, output int nr);
    int w0;
    int r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    if (!v.hold) req = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    er = err;
    nw = wr_cnt - w0;
    nr = rd_cnt - r0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nw;
    int          nr;
    int          w0;
    int          rc0;
    vec_t        v;

    checks = 0; errors = 0;
    wr_cnt = 0; rd_cnt = 0; rdy_cnt = 0; last_waddr = '0;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    //        we   sz     sx    addr           wdata          hold lat rd             er  nw nr chk idx   word
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 2, 32'h0,          1'b0, 1, 0, 1'b1, 2,    32'hDEAD_BEEF));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 2, 32'hDEAD_BEEF,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1122_3344, 1'b0, 2, 32'h0,          1'b0, 1, 0, 1'b1, 0,    32'h1122_3344));
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'hFFFF_FFAA, 1'b0, 3, 32'h0,          1'b0, 1, 1, 1'b1, 0,    32'h1122_AA44));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 2, 32'h1122_AA44,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h0000_80FF, 1'b0, 2, 32'h0,          1'b0, 1, 0, 1'b1, 0,    32'h0000_80FF));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h1001_0001, 32'h0,         1'b0, 2, 32'hFFFF_FF80,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h1001_0001, 32'h0,         1'b0, 2, 32'h0000_0080,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h8001_7F02, 1'b0, 2, 32'h0,          1'b0, 1, 0, 1'b1, 1,    32'h8001_7F02));
    tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0,         1'b0, 2, 32'hFFFF_8001,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 2, 32'h0000_7F02,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0,         1'b0, 2, 32'hFFFF_FF80,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h1001_0006, 32'h0,         1'b0, 2, 32'h0000_0001,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'h1234_5678, 1'b0, 3, 32'h0,          1'b0, 1, 1, 1'b1, 1,    32'h5678_7F02));
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 32'h1001_0004, 32'h0000_005A, 1'b0, 3, 32'h0,          1'b0, 1, 1, 1'b1, 1,    32'h5678_7F5A));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 2, 32'h5678_7F5A,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0,         1'b0, 1, 32'h0,          1'b1, 0, 0, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0FFF_FFFC, 32'h0,         1'b0, 1, 32'h0,          1'b1, 0, 0, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 1, 32'h0,          1'b1, 0, 0, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h0000_FFFF, 1'b0, 1, 32'h0,          1'b1, 0, 0, 1'b1, 0,    32'h0000_80FF));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'h0,         1'b0, 1, 32'h0,          1'b1, 0, 0, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 2, 32'h0,          1'b0, 1, 0, 1'b1, 1023, 32'hCAFE_F00D));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001_0FFC, 32'h0,         1'b0, 2, 32'hCAFE_F00D,  1'b0, 0, 1, 1'b0, 0,    32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'h1111_1111, 1'b1, 2, 32'h0,          1'b0, 1, 0, 1'b1, 3,    32'h1111_1111));
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 32'h1001_000E, 32'h0000_0099, 1'b0, 3, 32'h0,          1'b0, 1, 1, 1'b1, 3,    32'h1199_1111));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",     32'(ready),     32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_mem_read",  32'(mem_read),  32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_rdata",     rdata,          32'h0);
    chk("rst_err",       32'(err),       32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven requests, issued back to back.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      run(v, lat, rd, er, nw, nr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_rdata", i),   rd,       v.rd);
      chk($sformatf("v%0d_err", i),     32'(er),  32'(v.er));
      chk($sformatf("v%0d_writes", i),  32'(nw),  32'(v.nw));
      chk($sformatf("v%0d_reads", i),   32'(nr),  32'(v.nr));
      chk($sformatf("v%0d_idle_ready", i), 32'(ready), 32'h0);
      if (v.nw == 1) chk($sformatf("v%0d_mem_addr", i), 32'(last_waddr), 32'(v.idx));
      if (v.chk)     chk($sformatf("v%0d_word", i), ram[v.idx], v.word);
    end
    req = 1'b0;

    // Reset while a halfword read-modify-write sits in WRITE.
    req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0;
    addr = 32'h1001_0004; wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rmw_busy_read", 32'(mem_read), 32'h1);
    @(posedge clk); #1;
    chk("rmw_in_write", 32'(mem_write), 32'h1);
    w0  = wr_cnt;
    rc0 = rdy_cnt;
    reset = 1'b0;
    #1;
    chk("rmw_write_gated", 32'(mem_write), 32'h0);
    @(posedge clk); #1;
    chk("abort_busy",  32'(busy),  32'h0);
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_rdata", rdata,      32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_word",     ram[1],                32'h5678_7F5A);
    chk("abort_no_write", 32'(wr_cnt - w0),      32'h0);
    chk("abort_no_ready", 32'(rdy_cnt - rc0),    32'h0);
    chk("abort_idle",     32'(busy),             32'h0);

    // A fresh request after the aborted one completes normally.
    v = mk(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 2, 32'h5678_7F5A, 1'b0, 0, 1, 1'b0, 0, 32'h0);
    run(v, lat, rd, er, nw, nr);
    chk("post_latency", 32'(lat), 32'd2);
    chk("post_rdata",   rd,       32'h5678_7F5A);
    chk("post_err",     32'(er),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
